// File: rtl/sum_board_serial_if.sv
// Board-side signal bundle for sum_board_serial: switches and buttons in,
// LED digit and status flags out.
interface sum_board_serial_if #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int SW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   logic             ena;
   logic [DIGIT-1:0] din;
   logic [SW-1:0]    sel;
   logic             load_a;
   logic             load_b;
   logic             start;
   logic             sub;
   logic             c_in;
   logic [DIGIT-1:0] disp;
   logic             co;
   logic             ovf;
   logic             busy;
   logic             done;

   modport master (
      output ena, din, sel, load_a, load_b, start, sub, c_in,
      input  disp, co, ovf, busy, done
   );

   modport slave (
      input  ena, din, sel, load_a, load_b, start, sub, c_in,
      output disp, co, ovf, busy, done
   );
endinterface

// File: rtl/sum_board_serial.sv
// Digit-serial add/subtract unit driven from board switches and buttons;
// operands are entered and the result read back one DIGIT at a time.
module sum_board_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input logic               clk,
   input logic               rst,
   sum_board_serial_if.slave bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int SW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [SW:0] NDIG_L = (SW + 1)'(NDIG);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic [2:0]       btn_p0, btn_p1, btn_p2, pulse;
   logic [WIDTH-1:0] a_r, b_r, res_r;
   logic [SW-1:0]    k;
   logic             carry, mode_r, co_r, ovf_r, busy_r, done_r;
   logic [DIGIT-1:0] a_dig, b_dig, bx_dig, disp_c;
   logic [DIGIT:0]   sum;
   logic             load_ok;

   function automatic logic ovf_of(input logic a_msb, input logic bx_msb,
                                   input logic s_msb);
      return (a_msb == bx_msb) && (s_msb != a_msb);
   endfunction

   // Button capture: two synchroniser flops plus a delay flop for edge detect
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_p0 <= '0;
         btn_p1 <= '0;
         btn_p2 <= '0;
      end else begin
         btn_p0 <= {bus.start, bus.load_b, bus.load_a};
         btn_p1 <= btn_p0;
         btn_p2 <= btn_p1;
      end
   end

   assign pulse   = btn_p1 & ~btn_p2;
   assign load_ok = bus.ena && (state == IDLE) && ({1'b0, bus.sel} < NDIG_L);

   always_comb begin
      a_dig  = '0;
      b_dig  = '0;
      disp_c = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (k == SW'(i)) begin
            a_dig = a_r[i*DIGIT +: DIGIT];
            b_dig = b_r[i*DIGIT +: DIGIT];
         end
         if (bus.sel == SW'(i)) disp_c = res_r[i*DIGIT +: DIGIT];
      end
      bx_dig = b_dig ^ {DIGIT{mode_r}};
      sum    = {1'b0, a_dig} + {1'b0, bx_dig} + {{DIGIT{1'b0}}, carry};
   end

   // Control FSM and digit-serial datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_r    <= '0;
         b_r    <= '0;
         res_r  <= '0;
         k      <= '0;
         carry  <= 1'b0;
         mode_r <= 1'b0;
         co_r   <= 1'b0;
         ovf_r  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               for (int i = 0; i < NDIG; i++) begin
                  if (load_ok && bus.sel == SW'(i)) begin
                     if (pulse[0]) a_r[i*DIGIT +: DIGIT] <= bus.din;
                     if (pulse[1]) b_r[i*DIGIT +: DIGIT] <= bus.din;
                  end
               end
               if (pulse[2]) begin
                  state  <= CALC;
                  res_r  <= '0;
                  k      <= '0;
                  mode_r <= bus.sub;
                  carry  <= bus.sub ? 1'b1 : bus.c_in;
                  busy_r <= 1'b1;
               end
            end
            CALC: begin
               for (int i = 0; i < NDIG; i++) begin
                  if (k == SW'(i)) res_r[i*DIGIT +: DIGIT] <= sum[DIGIT-1:0];
               end
               carry <= sum[DIGIT];
               k     <= k + 1'b1;
               if (k == SW'(NDIG - 1)) begin
                  state  <= DONE;
                  co_r   <= sum[DIGIT];
                  ovf_r  <= ovf_of(a_dig[DIGIT-1], bx_dig[DIGIT-1], sum[DIGIT-1]);
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
               end
            end
            DONE: begin
               done_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.disp = disp_c;
   assign bus.co   = co_r;
   assign bus.ovf  = ovf_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;
endmodule
